sub_bytes_multi: RTL and testbench

Parametrised AES SubBytes/InvSubBytes engine: substitutes the 16 bytes of a 128-bit state through the forward or inverse S-box, `LANES` bytes per clock. It is the next generation of the serial one-byte-per-cycle SubBytes unit, adding lane width, inverse mode, busy/done handshaking and a result register that is held stable. It sits in the AES round datapath between AddRoundKey and ShiftRows.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox.sv | 15 +
 rtl/sub_bytes_multi.sv | 114 +++++++++++
 tb/tb_sub_bytes_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block size, forward/inverse S-box tables, SubBytes FSM states.
package aes_pkg;

    localparam int BLOCK_BYTES = 16;

    // 16 bytes of AES state; byte k of the 128-bit word lives in element [15-k].
    typedef logic [BLOCK_BYTES-1:0][7:0] blk_bytes_t;

    typedef enum logic {
        IDLE = 1'b0,
        PROC = 1'b1
    } sb_state_t;

    // Map a byte number (0 = MSB of the 128-bit word) onto its packed element.
    function automatic logic [3:0] byte_slot(input logic [3:0] k);
        return 4'd15 - k;
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, forward or inverse selected by inv.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    // Pure table lookup; no state.
    always_comb begin
        out = inv ? INV_SBOX[in] : SBOX[in];
    end

endmodule

// File: rtl/sub_bytes_multi.sv
// AES SubBytes/InvSubBytes engine: substitutes a 128-bit state LANES bytes per clock,
// with a busy/done handshake and a result register that only changes on completion.
module sub_bytes_multi
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         inv,
    input  logic [127:0] b,
    output logic         busy,
    output logic         done,
    output logic [127:0] b_sb
);

    localparam int N     = BLOCK_BYTES / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_multi: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    blk_bytes_t       work_q, work_d;
    logic [127:0]     b_sb_q, b_sb_d;
    logic             done_q, done_d;

    logic [3:0]       lane_idx [LANES];
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    // Lane muxes: lane l looks at byte cnt*LANES + l of the working register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
            lane_in[l]  = work_q[byte_slot(lane_idx[l])];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .in  (lane_in[g]),
            .inv (mode_q),
            .out (lane_out[g])
        );
    end

    // Next-state logic: capture on start, substitute one group per cycle, publish on the last group.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        b_sb_d  = b_sb_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PROC;
                    cnt_d   = '0;
                    mode_d  = inv;
                    work_d  = b;
                end
            end
            PROC: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[byte_slot(lane_idx[l])] = lane_out[l];
                end
                if (cnt_q == CNT_LAST) begin
                    // The substituted state goes straight to the result register on this edge.
                    state_d = IDLE;
                    cnt_d   = '0;
                    b_sb_d  = work_d;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            b_sb_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            b_sb_q  <= b_sb_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == PROC);
    assign done = done_q;
    assign b_sb = b_sb_q;

endmodule

// File: tb/tb_sub_bytes_multi.sv
// Self-checking bench for sub_bytes_multi at LANES = 1, 4 and 16.
module tb_sub_bytes_multi;

    localparam int NL = 3;

    function automatic int lanes_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NL-1:0]        rst_s, start_s, inv_s, busy_s, done_s;
    logic [NL-1:0][127:0] b_s, bsb_s;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        sub_bytes_multi #(.LANES(lanes_of(g))) u_dut (
            .clk   (clk),
            .rst   (rst_s[g]),
            .start (start_s[g]),
            .inv   (inv_s[g]),
            .b     (b_s[g]),
            .busy  (busy_s[g]),
            .done  (done_s[g]),
            .b_sb  (bsb_s[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cur_lanes = 0;
    logic [127:0] prev_q [NL];
    logic [7:0]   sref [256];
    logic [7:0]   iref [256];

    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] ALL16 = {16{8'h16}};
    localparam logic [127:0] ALLFF = {16{8'hff}};

    typedef struct {
        logic [127:0] b;
        logic         inv;
        logic [127:0] exp;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s lanes=%0d actual=%h required=%h", nm, cur_lanes, act, req);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = c;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_model();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] xi, r, s;
            xi = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(v), 8'(y)) == 8'h01) xi = 8'(y);
            end
            s = xi; r = xi;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            s = s ^ 8'h63;
            sref[v] = s;
        end
        for (int v = 0; v < 256; v++) iref[sref[v]] = 8'(v);
    endtask

    function automatic logic [127:0] model(input logic [127:0] blk, input logic md);
        logic [127:0] r, t;
        r = '0; t = blk;
        for (int k = 0; k < 16; k++) begin
            r = {r[119:0], md ? iref[t[127:120]] : sref[t[127:120]]};
            t = {t[119:0], 8'h00};
        end
        return r;
    endfunction

    // One full operation with latency, hold, pulse-width and result checks.
    task automatic run_op(input int li, input logic [127:0] bin, input logic md,
                          input logic [127:0] exp, input bit scramble);
        int n, k;
        bit seen;
        n = 16 / lanes_of(li);
        @(negedge clk);
        start_s[li] = 1'b1; b_s[li] = bin; inv_s[li] = md;
        @(negedge clk);
        start_s[li] = 1'b0;
        chk("busy_rise", 128'(busy_s[li]), 128'(1));
        chk("done_low_at_start", 128'(done_s[li]), 128'(0));
        k = 0; seen = 0;
        while (!seen && k < n + 4) begin
            if (scramble) begin
                b_s[li]   = {$urandom, $urandom, $urandom, $urandom};
                inv_s[li] = 1'($urandom);
            end
            @(negedge clk);
            k++;
            if (done_s[li]) seen = 1;
            else chk("hold_during_proc", bsb_s[li], prev_q[li]);
        end
        chk("latency", 128'(k), 128'(n));
        chk("result", bsb_s[li], exp);
        chk("busy_fall", 128'(busy_s[li]), 128'(0));
        prev_q[li] = exp;
        @(negedge clk);
        chk("done_one_cycle", 128'(done_s[li]), 128'(0));
        chk("result_stable", bsb_s[li], exp);
    endtask

    // Second start and input changes while busy must not disturb the running operation.
    task automatic hold_ignore(input int li);
        int n, nd, kd;
        logic [127:0] at_done;
        n = 16 / lanes_of(li);
        @(negedge clk);
        start_s[li] = 1'b1; b_s[li] = '0; inv_s[li] = 1'b0;
        @(negedge clk);
        chk("ignore_busy", 128'(busy_s[li]), 128'(1));
        start_s[li] = 1'b1; b_s[li] = ALLFF; inv_s[li] = 1'b1;
        nd = 0; kd = 0; at_done = '0;
        for (int c = 1; c <= n + 6; c++) begin
            @(negedge clk);
            if (done_s[li]) begin
                nd++; at_done = bsb_s[li]; kd = c;
            end else if (nd == 0) begin
                chk("ignore_hold", bsb_s[li], prev_q[li]);
            end
            if (c == 1) start_s[li] = 1'b0;
        end
        chk("ignore_done_count", 128'(nd), 128'(1));
        chk("ignore_result", at_done, ALL63);
        chk("ignore_latency", 128'(kd), 128'(n));
        prev_q[li] = ALL63;
    endtask

    // start held high: the next block is taken in the done cycle, so dones are N+1 edges apart.
    task automatic back_to_back(input int li);
        int n, k;
        bit seen;
        n = 16 / lanes_of(li);
        @(negedge clk);
        start_s[li] = 1'b1; b_s[li] = ALLFF; inv_s[li] = 1'b0;
        @(negedge clk);
        b_s[li] = '0;
        k = 0; seen = 0;
        while (!seen && k < n + 4) begin
            @(negedge clk); k++;
            if (done_s[li]) seen = 1;
        end
        chk("b2b_latency1", 128'(k), 128'(n));
        chk("b2b_result1", bsb_s[li], ALL16);
        k = 0; seen = 0;
        while (!seen && k < n + 5) begin
            @(negedge clk); k++;
            if (k == 1) begin
                chk("b2b_rearmed", 128'(busy_s[li]), 128'(1));
                start_s[li] = 1'b0;
            end
            if (done_s[li]) seen = 1;
        end
        chk("b2b_gap", 128'(k), 128'(n + 1));
        chk("b2b_result2", bsb_s[li], ALL63);
        prev_q[li] = ALL63;
        @(negedge clk);
        chk("b2b_done_drop", 128'(done_s[li]), 128'(0));
    endtask

    // Reset on the first processing edge aborts the operation without a done.
    task automatic reset_mid(input int li);
        int n;
        n = 16 / lanes_of(li);
        @(negedge clk);
        start_s[li] = 1'b1; b_s[li] = {$urandom, $urandom, $urandom, $urandom}; inv_s[li] = 1'b0;
        @(negedge clk);
        start_s[li] = 1'b0; rst_s[li] = 1'b1;
        @(negedge clk);
        chk("rst_busy", 128'(busy_s[li]), 128'(0));
        chk("rst_done", 128'(done_s[li]), 128'(0));
        chk("rst_result", bsb_s[li], 128'(0));
        rst_s[li] = 1'b0;
        for (int c = 0; c < n + 4; c++) begin
            @(negedge clk);
            chk("rst_no_done", 128'(done_s[li]), 128'(0));
        end
        prev_q[li] = '0;
        run_op(li, vt[0].b, vt[0].inv, vt[0].exp, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog lanes=%0d actual=timeout required=finish", cur_lanes);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{b: 128'h00112233445566778899aabbccddeeff, inv: 1'b0, exp: 128'h638293c31bfc33f5c4eeacea4bc12816};
        vt[1] = '{b: 128'h638293c31bfc33f5c4eeacea4bc12816, inv: 1'b1, exp: 128'h00112233445566778899aabbccddeeff};
        vt[2] = '{b: ALLFF, inv: 1'b0, exp: ALL16};
        vt[3] = '{b: 128'h0,  inv: 1'b0, exp: ALL63};

        build_model();
        rst_s = '1; start_s = '0; inv_s = '0; b_s = '0;
        repeat (3) @(negedge clk);
        for (int li = 0; li < NL; li++) begin
            cur_lanes = lanes_of(li);
            chk("reset_busy", 128'(busy_s[li]), 128'(0));
            chk("reset_done", 128'(done_s[li]), 128'(0));
            chk("reset_result", bsb_s[li], 128'(0));
            prev_q[li] = '0;
        end
        rst_s = '0;

        for (int li = 0; li < NL; li++) begin
            cur_lanes = lanes_of(li);
            for (int i = 0; i < 4; i++) run_op(li, vt[i].b, vt[i].inv, vt[i].exp, 0);
            run_op(li, vt[0].b, vt[0].inv, vt[0].exp, 0);
            hold_ignore(li);
            back_to_back(li);
            reset_mid(li);
            for (int i = 0; i < 20; i++) begin
                logic [127:0] rb;
                logic md;
                rb = {$urandom, $urandom, $urandom, $urandom};
                md = 1'($urandom);
                run_op(li, rb, md, model(rb, md), 1);
            end
            for (int v = 0; v < 256; v++) begin
                run_op(li, {16{8'(v)}}, 1'b0, {16{sref[v]}}, 0);
                run_op(li, {16{sref[v]}}, 1'b1, {16{8'(v)}}, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
